nibble_serial_alu_ctrl: RTL and testbench
=========================================

NIBBLE_SERIAL_ALU_CTRL -- requirements
Module: nibble_serial_alu_ctrl

Interface
REQ-001 SHALL have port clk_i, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-003 SHALL have port valid_i, input, 1, upstream operation request.
REQ-004 SHALL have port ready_o, output, 1, controller can accept an operation.
REQ-005 SHALL have port a_i, input, 16, operand A.
REQ-006 SHALL have port b_i, input, 16, operand B.
REQ-007 SHALL have ports sel_i (input, 4), mode_i (input, 1) and carry_i (input, 1), carrying the ALU function select, the logic/arithmetic mode and the carry-in.
REQ-008 SHALL have ports slice_a_o and slice_b_o, output, 4 each, nibble operands to the 4-bit ALU slice.
REQ-009 SHALL have ports slice_sel_o (output, 4), slice_mode_o (output, 1) and slice_carry_o (output, 1), driving the slice select, mode and carry-in.
REQ-010 SHALL have ports slice_f_i (input, 4), slice_carry_i (input, 1), slice_gp_i (input, 1) and slice_gg_i (input, 1), returning the slice result, carry-out, group propagate and group generate.
REQ-011 SHALL have port result_o, output, 16, assembled result.
REQ-012 SHALL have port carry_o, output, 1, final carry-out.
REQ-013 SHALL have ports zero_o and equal_o, output, 1 each, flagging result==0x0000 and result==0xFFFF respectively.
REQ-014 SHALL have ports gp_o and gg_o, output, 4 each, holding per-nibble group propagate/generate, with bit k for nibble k.
REQ-015 SHALL have port valid_o, output, 1, result available.
REQ-016 SHALL have port ready_i, input, 1, downstream accepts result.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL assert ready_o only in IDLE; accept occurs on a cycle with valid_i & ready_o, which latches a_i, b_i, sel_i, mode_i and carry_i, clears nibble index k to 0, and moves to RUN.
REQ-019 SHALL, in RUN, drive slice_a_o=A[4k+3:4k], slice_b_o=B[4k+3:4k], slice_sel_o=latched sel and slice_mode_o=latched mode, all registered-stable for the whole cycle.
REQ-020 SHALL drive slice_carry_o = latched carry_i when k=0, and the slice_carry_i value captured in the previous RUN cycle when k>0.
REQ-021 SHALL, at the end of each RUN cycle, capture slice_f_i into result bits [4k+3:4k], slice_gp_i into gp_o[k] and slice_gg_i into gg_o[k], then increment k.
REQ-022 SHALL, at the end of the RUN cycle with k=3, capture slice_carry_i into carry_o, update zero_o and equal_o from the complete result, and move to DONE.
REQ-023 SHALL pass the carry chain identically in both modes, even though the slice ignores it in logic mode (mode=1).
REQ-024 SHALL treat the slice as combinational; total latency from the accept edge to valid_o high is exactly 5 cycles.
REQ-025 SHALL assert valid_o only in DONE and move to IDLE on valid_o & ready_i; while ready_i is low, result_o, carry_o, zero_o, equal_o, gp_o and gg_o SHALL hold.
REQ-026 SHALL hold result_o and flags stable outside DONE at their last completed values; valid_i while not ready_o SHALL be ignored, with no queuing.
REQ-027 SHALL drive slice_a_o, slice_b_o and slice_carry_o to 0 outside RUN.
REQ-028 SHALL deliver a maximum throughput of one operation per 6 cycles; there is no overlap between operations.

Reset
REQ-029 SHALL, on rst_i high at a clock edge, enter IDLE from any state, including mid-RUN, abandoning the operation.
REQ-030 SHALL, after reset, set ready_o=1, valid_o=0, result_o=0, carry_o=0, zero_o=1, equal_o=0, gp_o=0, gg_o=0 and all slice_* outputs=0.

Verification
REQ-031 SHALL verify add (bench slice model): sel=1001, mode=0, a=0x1234, b=0x0FFF, carry_i=0 -> result 0x2233, carry_o=0, zero_o=0, valid_o exactly 5 cycles after accept.
REQ-032 SHALL verify add wrap: sel=1001, mode=0, a=0xFFFF, b=0x0001, carry_i=0 -> result 0x0000, carry_o=1, zero_o=1; slice_carry_o seen as 0,1,1,1 over the 4 RUN cycles.
REQ-033 SHALL verify logic: sel=1001, mode=1, a=0xA5A5, b=0xA5A5 -> result 0xFFFF (XNOR), equal_o=1.
REQ-034 SHALL verify backpressure: ready_i held low for 10 cycles in DONE -> valid_o and result stay constant, ready_o stays 0, and valid_i pulses are ignored; a ready_i pulse returns the FSM to IDLE next cycle.
REQ-035 SHALL verify reset: rst_i asserted during the RUN cycle with k=2 -> next cycle IDLE with the REQ-030 values; a new operation afterward completes correctly.
REQ-036 SHALL verify back-to-back: valid_i held high with two operations -> second accept occurs the cycle after the first DONE handshake, and both results are correct.

Source files
------------

// File: rtl/nibble_serial_alu_ctrl_if.sv
// Bundle for the nibble-serial ALU controller. It carries the upstream
// operation handshake, the 4-bit slice drive/return path and the
// downstream result handshake.
interface nibble_serial_alu_ctrl_if;
    // upstream operation request
    logic        valid_i;
    logic        ready_o;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic [3:0]  sel_i;
    logic        mode_i;
    logic        carry_i;
    // drive to the 4-bit ALU slice
    logic [3:0]  slice_a_o;
    logic [3:0]  slice_b_o;
    logic [3:0]  slice_sel_o;
    logic        slice_mode_o;
    logic        slice_carry_o;
    // return from the slice
    logic [3:0]  slice_f_i;
    logic        slice_carry_i;
    logic        slice_gp_i;
    logic        slice_gg_i;
    // downstream result
    logic [15:0] result_o;
    logic        carry_o;
    logic        zero_o;
    logic        equal_o;
    logic [3:0]  gp_o;
    logic [3:0]  gg_o;
    logic        valid_o;
    logic        ready_i;

    // controller side
    modport slave (
        input  valid_i, a_i, b_i, sel_i, mode_i, carry_i,
        input  slice_f_i, slice_carry_i, slice_gp_i, slice_gg_i,
        input  ready_i,
        output ready_o,
        output slice_a_o, slice_b_o, slice_sel_o, slice_mode_o, slice_carry_o,
        output result_o, carry_o, zero_o, equal_o, gp_o, gg_o, valid_o
    );

    // environment side: requester, slice and result consumer
    modport master (
        output valid_i, a_i, b_i, sel_i, mode_i, carry_i,
        output slice_f_i, slice_carry_i, slice_gp_i, slice_gg_i,
        output ready_i,
        input  ready_o,
        input  slice_a_o, slice_b_o, slice_sel_o, slice_mode_o, slice_carry_o,
        input  result_o, carry_o, zero_o, equal_o, gp_o, gg_o, valid_o
    );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Nibble-serial 16-bit ALU controller. It sequences one 4-bit combinational
// ALU slice over four cycles, LSB nibble first, and ripples the slice carry
// through a register between cycles. Results are built in working
// registers and published all at once on the last nibble, so the visible
// result and flags only change when an operation completes.
module nibble_serial_alu_ctrl (
    input  logic                      clk_i,
    input  logic                      rst_i,
    nibble_serial_alu_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;

    // latched operation
    logic [15:0] a_q, b_q;
    logic [3:0]  sel_q;
    logic        mode_q, cin_q;

    // nibble sequencing
    logic [1:0]  k_q;
    logic        chain_q;
    logic        accept;
    logic        last_nib;

    // in-flight work and published results
    logic [15:0] work_res_q, res_next;
    logic [3:0]  work_gp_q, work_gg_q, gp_next, gg_next;
    logic [15:0] result_q;
    logic        carry_q, zero_q, equal_q;
    logic [3:0]  gp_q, gg_q;

    assign accept   = (state_q == IDLE) && bus.valid_i;
    assign last_nib = (state_q == RUN) && (k_q == 2'd3);

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state and handshake outputs
    always_comb begin
        state_d     = state_q;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ready_o = 1'b1;
                if (bus.valid_i) state_d = RUN;
            end
            RUN: begin
                if (k_q == 2'd3) state_d = DONE;
            end
            DONE: begin
                bus.valid_o = 1'b1;
                if (bus.ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // slice drive: a mux of registered state only, so it is stable for the
    // whole RUN cycle; everything is parked at zero outside RUN
    always_comb begin
        bus.slice_a_o     = 4'h0;
        bus.slice_b_o     = 4'h0;
        bus.slice_sel_o   = 4'h0;
        bus.slice_mode_o  = 1'b0;
        bus.slice_carry_o = 1'b0;
        if (state_q == RUN) begin
            bus.slice_a_o     = a_q[{k_q, 2'b00} +: 4];
            bus.slice_b_o     = b_q[{k_q, 2'b00} +: 4];
            bus.slice_sel_o   = sel_q;
            bus.slice_mode_o  = mode_q;
            bus.slice_carry_o = (k_q == 2'd0) ? cin_q : chain_q;
        end
    end

    // merge this cycle's slice return into the working values
    always_comb begin
        res_next                    = work_res_q;
        res_next[{k_q, 2'b00} +: 4] = bus.slice_f_i;
        gp_next                     = work_gp_q;
        gp_next[k_q]                = bus.slice_gp_i;
        gg_next                     = work_gg_q;
        gg_next[k_q]                = bus.slice_gg_i;
    end

    // operand latch, nibble index and carry ripple; the carry is passed on
    // in logic mode too, the slice just ignores it there
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            cin_q   <= 1'b0;
            k_q     <= '0;
            chain_q <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.a_i;
            b_q     <= bus.b_i;
            sel_q   <= bus.sel_i;
            mode_q  <= bus.mode_i;
            cin_q   <= bus.carry_i;
            k_q     <= '0;
            chain_q <= 1'b0;
        end else if (state_q == RUN) begin
            k_q     <= k_q + 2'd1;
            chain_q <= bus.slice_carry_i;
        end
    end

    // accumulate per-nibble results; publish result and flags on the last
    // nibble and hold them until the next completion
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            work_res_q <= '0;
            work_gp_q  <= '0;
            work_gg_q  <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
            equal_q    <= 1'b0;
            gp_q       <= '0;
            gg_q       <= '0;
        end else if (state_q == RUN) begin
            work_res_q <= res_next;
            work_gp_q  <= gp_next;
            work_gg_q  <= gg_next;
            if (last_nib) begin
                result_q <= res_next;
                gp_q     <= gp_next;
                gg_q     <= gg_next;
                carry_q  <= bus.slice_carry_i;
                zero_q   <= (res_next == 16'h0000);
                equal_q  <= (res_next == 16'hFFFF);
            end
        end
    end

    assign bus.result_o = result_q;
    assign bus.carry_o  = carry_q;
    assign bus.zero_o   = zero_q;
    assign bus.equal_o  = equal_q;
    assign bus.gp_o     = gp_q;
    assign bus.gg_o     = gg_q;

endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Bench for nibble_serial_alu_ctrl: a behavioural 4-bit slice, a vector
// table, a result scoreboard and hand-written multi-cycle sequences.
module tb_nibble_serial_alu_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_serial_alu_ctrl_if bus ();

    nibble_serial_alu_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sel;
        logic        mode;
        logic        cin;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        e;
        logic [3:0]  gp;
        logic [3:0]  gg;
    } vec_t;

    int   n_chk = 0;
    int   n_err = 0;
    vec_t sbq[$];
    vec_t tbl[8];

    logic [3:0] op_sel  [6] = '{4'b1001, 4'b0110, 4'b1001, 4'b0110, 4'b1011, 4'b1110};
    logic       op_mode [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // slice model: sel 0110 subtracts (A + ~B + C), other arithmetic selects
    // add; logic mode 1001 XNOR, 0110 XOR, 1011 AND, 1110 OR, else NOT A
    logic [3:0] sl_be;
    logic [4:0] sl_sum;
    always_comb begin
        sl_be  = (bus.slice_sel_o == 4'b0110) ? ~bus.slice_b_o : bus.slice_b_o;
        sl_sum = {1'b0, bus.slice_a_o} + {1'b0, sl_be} + {4'b0, bus.slice_carry_o};
        bus.slice_carry_i = sl_sum[4];
        bus.slice_gp_i    = &(bus.slice_a_o ^ sl_be);
        bus.slice_gg_i    = (({1'b0, bus.slice_a_o} + {1'b0, sl_be}) > 5'd15);
        bus.slice_f_i     = sl_sum[3:0];
        if (bus.slice_mode_o) begin
            case (bus.slice_sel_o)
                4'b1001: bus.slice_f_i = ~(bus.slice_a_o ^ bus.slice_b_o);
                4'b0110: bus.slice_f_i = bus.slice_a_o ^ bus.slice_b_o;
                4'b1011: bus.slice_f_i = bus.slice_a_o & bus.slice_b_o;
                4'b1110: bus.slice_f_i = bus.slice_a_o | bus.slice_b_o;
                default: bus.slice_f_i = ~bus.slice_a_o;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // whole-word reference for one operation
    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                                input logic [3:0] sel, input logic mode, input logic cin);
        vec_t        v;
        logic [15:0] beff;
        logic [16:0] s;
        logic [3:0]  an, bn;
        v.a = a; v.b = b; v.sel = sel; v.mode = mode; v.cin = cin;
        beff = (sel == 4'b0110) ? ~b : b;
        s    = {1'b0, a} + {1'b0, beff} + {16'b0, cin};
        v.res = s[15:0];
        if (mode) begin
            case (sel)
                4'b1001: v.res = ~(a ^ b);
                4'b0110: v.res = a ^ b;
                4'b1011: v.res = a & b;
                4'b1110: v.res = a | b;
                default: v.res = ~a;
            endcase
        end
        v.c = s[16];
        v.z = (v.res == 16'h0000);
        v.e = (v.res == 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            an = a[4*k +: 4];
            bn = beff[4*k +: 4];
            v.gp[k] = &(an ^ bn);
            v.gg[k] = (({1'b0, an} + {1'b0, bn}) > 5'd15);
        end
        return v;
    endfunction

    // result checker: pops on every downstream handshake
    always @(negedge clk) begin : mon
        vec_t x;
        if (!rst && bus.valid_o && bus.ready_i) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected: got result %0h expected no output", bus.result_o);
            end else begin
                x = sbq.pop_front();
                check("result", bus.result_o, x.res);
                check("carry",  bus.carry_o,  x.c);
                check("zero",   bus.zero_o,   x.z);
                check("equal",  bus.equal_o,  x.e);
                check("gp",     bus.gp_o,     x.gp);
                check("gg",     bus.gg_o,     x.gg);
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_ready_o"},   bus.ready_o,       1);
        check({tag, "_valid_o"},   bus.valid_o,       0);
        check({tag, "_result_o"},  bus.result_o,      0);
        check({tag, "_carry_o"},   bus.carry_o,       0);
        check({tag, "_zero_o"},    bus.zero_o,        1);
        check({tag, "_equal_o"},   bus.equal_o,       0);
        check({tag, "_gp_o"},      bus.gp_o,          0);
        check({tag, "_gg_o"},      bus.gg_o,          0);
        check({tag, "_slice_a"},   bus.slice_a_o,     0);
        check({tag, "_slice_b"},   bus.slice_b_o,     0);
        check({tag, "_slice_c"},   bus.slice_carry_o, 0);
        check({tag, "_slice_sel"}, bus.slice_sel_o,   0);
        check({tag, "_slice_md"},  bus.slice_mode_o,  0);
    endtask

    task automatic drive_op(input vec_t v);
        bus.a_i     = v.a;
        bus.b_i     = v.b;
        bus.sel_i   = v.sel;
        bus.mode_i  = v.mode;
        bus.carry_i = v.cin;
    endtask

    // one operation: accept, watch the RUN cycles, measure latency to valid_o
    task automatic send(input vec_t v, input bit bp, output logic [3:0] cseq);
        int          cnt;
        logic [15:0] held;
        @(posedge clk); #1;
        drive_op(v);
        bus.valid_i = 1'b1;
        if (bp) bus.ready_i = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!bus.ready_o && cnt < 50);
        check("accept", bus.ready_o, 1);
        held = bus.result_o;
        sbq.push_back(v);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        cnt  = 0;
        cseq = '0;
        do begin
            @(negedge clk);
            cnt++;
            if (!bus.valid_o && cnt <= 4) begin
                cseq[cnt-1] = bus.slice_carry_o;
                check("run_slice_a", bus.slice_a_o, v.a[4*(cnt-1) +: 4]);
                check("run_slice_b", bus.slice_b_o, v.b[4*(cnt-1) +: 4]);
                check("run_hold_result", bus.result_o, held);
            end
        end while (!bus.valid_o && cnt < 20);
        check("latency", cnt, 5);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        logic [3:0] cseq;
        vec_t       v, v2;
        int         cnt, idx;

        tbl[0] = mk(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b0);
        tbl[0].res = 16'h2233; tbl[0].c = 1'b0; tbl[0].z = 1'b0; tbl[0].e = 1'b0;
        tbl[1] = mk(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
        tbl[1].res = 16'h0000; tbl[1].c = 1'b1; tbl[1].z = 1'b1; tbl[1].e = 1'b0;
        tbl[2] = mk(16'hA5A5, 16'hA5A5, 4'b1001, 1'b1, 1'b0);
        tbl[2].res = 16'hFFFF; tbl[2].z = 1'b0; tbl[2].e = 1'b1;
        tbl[3] = mk(16'h0000, 16'h0000, 4'b1001, 1'b0, 1'b0);
        tbl[4] = mk(16'h8000, 16'h7FFF, 4'b0110, 1'b0, 1'b1);
        for (int i = 5; i < 8; i++) begin
            idx    = $urandom_range(0, 5);
            tbl[i] = mk(16'($urandom), 16'($urandom), op_sel[idx], op_mode[idx], 1'($urandom));
        end

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        drive_op(mk(16'h0, 16'h0, 4'h0, 1'b0, 1'b0));

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_state("rst");

        for (int i = 0; i < 8; i++) begin
            send(tbl[i], 1'b0, cseq);
            if (i == 1) check("wrap_carry_seq", cseq, 4'b1110);
        end

        // backpressure: hold ready_i low in DONE, poke valid_i meanwhile
        v = mk(16'h3C3C, 16'h1111, 4'b1001, 1'b0, 1'b1);
        send(v, 1'b1, cseq);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.valid_i = (i % 2 == 1);
            bus.a_i     = 16'($urandom);
            @(negedge clk);
            check("bp_valid_o", bus.valid_o,  1);
            check("bp_ready_o", bus.ready_o,  0);
            check("bp_result",  bus.result_o, v.res);
            check("bp_carry",   bus.carry_o,  v.c);
        end
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ready_i = 1'b0;
        @(negedge clk);
        check("bp_release_ready", bus.ready_o, 1);
        check("bp_release_valid", bus.valid_o, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_no_queue", bus.ready_o, 1);
        bus.ready_i = 1'b1;

        // reset in the k=2 RUN cycle abandons the operation
        v = mk(16'h4321, 16'h1111, 4'b1001, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive_op(v);
        bus.valid_i = 1'b1;
        @(negedge clk);
        check("mid_accept", bus.ready_o, 1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_k2_slice_a", bus.slice_a_o, 4'h3);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("mid");
        send(mk(16'h0F0F, 16'hF0F0, 4'b1001, 1'b1, 1'b0), 1'b0, cseq);

        // back-to-back: valid_i held high across two operations
        v  = mk(16'h7777, 16'h8889, 4'b1001, 1'b0, 1'b0);
        v2 = mk(16'h5555, 16'h1234, 4'b0110, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive_op(v);
        bus.valid_i = 1'b1;
        @(negedge clk);
        check("b2b_accept1", bus.ready_o, 1);
        sbq.push_back(v);
        @(posedge clk); #1;
        drive_op(v2);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!bus.ready_o && cnt < 20);
        check("b2b_gap", cnt, 6);
        sbq.push_back(v2);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!bus.valid_o && cnt < 20);
        check("b2b_latency2", cnt, 5);

        repeat (3) @(negedge clk);
        check("sb_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
